// File: rtl/ro_freq_counter_pkg.sv
// Shared types and constants for the ring-oscillator frequency counter.
package ro_meas_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_COUNT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Cycles spent in ARM so the synchroniser holds only post-latch samples
  localparam int unsigned ARM_CYCLES = 3;

  localparam logic BSEL_LO = 1'b0;
  localparam logic BSEL_HI = 1'b1;

  function automatic logic [7:0] pick_byte(input logic [15:0] word, input logic bsel);
    return (bsel == BSEL_HI) ? word[15:8] : word[7:0];
  endfunction

endpackage

// File: rtl/ro_freq_counter_if.sv
// Bundle of the counter's measurement control and result signals.
// The counter keeps flat ports; the harness side drives/observes through this bundle.
interface ro_freq_counter_if #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned WIN_W = 16
) (
  input logic clk
);

  logic [15:0]      ro_in;
  logic [3:0]       ro_sel;
  logic             xor_mode;
  logic [WIN_W-1:0] win_len;
  logic             start;
  logic             byte_sel;
  logic             busy;
  logic             done;
  logic             overflow;
  logic [CNT_W-1:0] count;
  logic [7:0]       data_out;

  modport master (
    input  clk,
    output ro_in, ro_sel, xor_mode, win_len, start, byte_sel,
    input  busy, done, overflow, count, data_out
  );

  modport slave (
    input  clk,
    input  ro_in, ro_sel, xor_mode, win_len, start, byte_sel,
    output busy, done, overflow, count, data_out
  );

endinterface

// File: rtl/ro_freq_counter_edge_sync.sv
// Two-flop synchroniser for an asynchronous bit plus a third stage for rising-edge detection.
module ro_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic [2:0] sync_q;
  logic [2:0] sync_d;

  always_comb begin
    sync_d = {sync_q[1:0], d};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign rise = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/ro_freq_counter.sv
// Gated edge counter for one ring oscillator of a 16-wide set.
// Define RO_XOR_EN to allow measuring the XOR of all 16 oscillator outputs.
module ro_freq_counter
  import ro_meas_pkg::*;
#(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned WIN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      ro_in,
  input  logic [3:0]       ro_sel,
  input  logic             xor_mode,
  input  logic [WIN_W-1:0] win_len,
  input  logic             start,
  input  logic             byte_sel,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic [CNT_W-1:0] count,
  output logic [7:0]       data_out
);

  state_e           state_q, state_d;
  logic [3:0]       sel_q, sel_d;
  logic [WIN_W-1:0] rem_q, rem_d;
  logic [1:0]       arm_q, arm_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             meas_bit;
  logic             rise;
  logic [15:0]      cnt_ext;

`ifdef RO_XOR_EN
  logic xor_q, xor_d;

  always_comb begin
    meas_bit = xor_q ? (^ro_in) : ro_in[sel_q];
  end
`else
  logic unused_xor_mode;

  assign unused_xor_mode = xor_mode;

  always_comb begin
    meas_bit = ro_in[sel_q];
  end
`endif

  ro_edge_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (meas_bit),
    .rise (rise)
  );

  // rem_q holds the latched window length and doubles as the COUNT cycle budget
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    rem_d   = rem_q;
    arm_d   = arm_q;
    count_d = count_q;
    ovf_d   = ovf_q;
`ifdef RO_XOR_EN
    xor_d   = xor_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_ARM;
          sel_d   = ro_sel;
          rem_d   = win_len;
          arm_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
`ifdef RO_XOR_EN
          xor_d   = xor_mode;
`endif
        end
      end
      ST_ARM: begin
        if (arm_q == 2'(ARM_CYCLES - 1)) begin
          state_d = (rem_q == '0) ? ST_DONE : ST_COUNT;
        end else begin
          arm_d = arm_q + 2'd1;
        end
      end
      ST_COUNT: begin
        if (rise) begin
          if (count_q == '1) begin
            ovf_d = 1'b1;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
        if (rem_q == WIN_W'(1)) begin
          state_d = ST_DONE;
        end else begin
          rem_d = rem_q - WIN_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_ARM) || (state_d == ST_COUNT);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      rem_q   <= '0;
      arm_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef RO_XOR_EN
      xor_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      rem_q   <= rem_d;
      arm_q   <= arm_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef RO_XOR_EN
      xor_q   <= xor_d;
`endif
    end
  end

  always_comb begin
    cnt_ext              = '0;
    cnt_ext[CNT_W-1:0]   = count_q;
    data_out             = pick_byte(cnt_ext, byte_sel);
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = ovf_q;
  assign count    = count_q;

endmodule

// File: tb/tb_ro_freq_counter.sv
// Scoreboard bench for ro_freq_counter: stimulus pushes expected results, monitors check them on done.
module tb_ro_freq_counter;

`ifdef RO_XOR_EN
  localparam bit XOR_EN = 1'b1;
`else
  localparam bit XOR_EN = 1'b0;
`endif

  typedef struct {
    int cnt;
    int ovf;
    int done_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   failures = 0;

  exp_t q16[$];
  exp_t q4[$];

  int          wmode = 0;
  logic [15:0] wmask = 16'h0000;
  int          whp = 4;
  logic [15:0] rtab [0:1023];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ro_freq_counter_if #(.CNT_W(16), .WIN_W(16)) bus  (.clk(clk));
  ro_freq_counter_if #(.CNT_W(4),  .WIN_W(16)) bus4 (.clk(clk));

  ro_freq_counter #(.CNT_W(16), .WIN_W(16)) dut (
    .clk(clk), .rst(rst), .ro_in(bus.ro_in), .ro_sel(bus.ro_sel), .xor_mode(bus.xor_mode),
    .win_len(bus.win_len), .start(bus.start), .byte_sel(bus.byte_sel), .busy(bus.busy),
    .done(bus.done), .overflow(bus.overflow), .count(bus.count), .data_out(bus.data_out)
  );

  ro_freq_counter #(.CNT_W(4), .WIN_W(16)) dut4 (
    .clk(clk), .rst(rst), .ro_in(bus4.ro_in), .ro_sel(bus4.ro_sel), .xor_mode(bus4.xor_mode),
    .win_len(bus4.win_len), .start(bus4.start), .byte_sel(bus4.byte_sel), .busy(bus4.busy),
    .done(bus4.done), .overflow(bus4.overflow), .count(bus4.count), .data_out(bus4.data_out)
  );

  // Oscillator waveform as a pure function of the cycle index
  function automatic logic [15:0] wave(input int n);
    if (wmode == 0) return ((n / whp) % 2 == 1) ? wmask : 16'h0000;
    return rtab[n % 1024];
  endfunction

  function automatic logic measured(input logic [15:0] w, input logic [3:0] sel, input logic xm);
    if (XOR_EN && xm) return ^w;
    return w[sel];
  endfunction

  // Rising edges of the sampled bit that land inside the gate window opened by start at edge k
  function automatic int edges(input int k, input int win, input logic [3:0] sel, input logic xm);
    int n = 0;
    for (int e = k + 2; e <= k + 1 + win; e++) begin
      if (measured(wave(e - 1), sel, xm) && !measured(wave(e - 2), sel, xm)) n++;
    end
    return n;
  endfunction

  function automatic int byte_of(input int cnt, input logic bsel);
    return bsel ? ((cnt >> 8) & 255) : (cnt & 255);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    logic [15:0] w;
    w = wave(cyc);
    bus.ro_in  = w;
    bus4.ro_in = w;
  end

  logic prev_done = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (bus.done && !prev_done) begin
      if (q16.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = q16.pop_front();
        check("done_cycle", cyc, e.done_cyc);
        check("count", int'(bus.count), e.cnt);
        check("overflow", int'(bus.overflow), e.ovf);
        check("data_out", int'(bus.data_out), byte_of(e.cnt, bus.byte_sel));
      end
    end
    prev_done = bus.done;
  end

  logic prev_done4 = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (bus4.done && !prev_done4) begin
      if (q4.size() == 0) begin
        check("unexpected_done4", 1, 0);
      end else begin
        e = q4.pop_front();
        check("done_cycle4", cyc, e.done_cyc);
        check("count4", int'(bus4.count), e.cnt);
        check("overflow4", int'(bus4.overflow), e.ovf);
        check("data_out4", int'(bus4.data_out), byte_of(e.cnt, bus4.byte_sel));
      end
    end
    prev_done4 = bus4.done;
  end

  task automatic issue(input logic [3:0] sel, input logic xm, input int win, input logic bsel);
    exp_t e;
    int   k;
    int   n;
    @(negedge clk);
    bus.ro_sel   = sel;
    bus.xor_mode = xm;
    bus.win_len  = 16'(win);
    bus.byte_sel = bsel;
    bus.start    = 1'b1;
    k = cyc + 1;
    n = edges(k, win, sel, xm);
    e.cnt      = (n > 65535) ? 65535 : n;
    e.ovf      = (n > 65535) ? 1 : 0;
    e.done_cyc = k + 3 + win;
    q16.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Issue a measurement and track busy until done; optionally disturb inputs mid-COUNT
  task automatic run(input logic [3:0] sel, input logic xm, input int win, input logic bsel, input bit disturb);
    issue(sel, xm, win, bsel);
    for (int c = 0; c < win + 3; c++) begin
      check("busy", int'(bus.busy), 1);
      if (disturb && c == 5 && win > 8) begin
        bus.ro_sel   = sel + 4'd7;
        bus.xor_mode = ~xm;
        bus.win_len  = 16'(win + 9);
        bus.start    = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    check("busy_end", int'(bus.busy), 0);
    check("done_level", int'(bus.done), 1);
  endtask

  task automatic run4(input int win);
    exp_t e;
    int   k;
    int   n;
    @(negedge clk);
    bus4.ro_sel   = 4'd0;
    bus4.xor_mode = 1'b0;
    bus4.win_len  = 16'(win);
    bus4.byte_sel = 1'b0;
    bus4.start    = 1'b1;
    k = cyc + 1;
    n = edges(k, win, 4'd0, 1'b0);
    e.cnt      = (n > 15) ? 15 : n;
    e.ovf      = (n > 15) ? 1 : 0;
    e.done_cyc = k + 3 + win;
    q4.push_back(e);
    @(negedge clk);
    bus4.start = 1'b0;
    repeat (win + 3) @(negedge clk);
    check("done4_level", int'(bus4.done), 1);
    bus4.byte_sel = 1'b1;
    #1;
    check("data_out4_hi", int'(bus4.data_out), 0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, int'(bus.busy), 0);
    check({tag, "_done"}, int'(bus.done), 0);
    check({tag, "_overflow"}, int'(bus.overflow), 0);
    check({tag, "_count"}, int'(bus.count), 0);
    check({tag, "_data_out"}, int'(bus.data_out), 0);
    check({tag, "_count4"}, int'(bus4.count), 0);
    check({tag, "_done4"}, int'(bus4.done), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) rtab[i] = 16'($urandom);
    bus.ro_sel = '0;  bus.xor_mode = 1'b0;  bus.win_len = '0;  bus.start = 1'b0;  bus.byte_sel = 1'b0;
    bus4.ro_sel = '0; bus4.xor_mode = 1'b0; bus4.win_len = '0; bus4.start = 1'b0; bus4.byte_sel = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_zero("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    // Oscillator 3 toggling every 4 cycles over a 64-cycle gate
    wmode = 0; wmask = 16'h0008; whp = 4;
    run(4'd3, 1'b0, 64, 1'b0, 1'b0);
    check("toggle3_count", int'(bus.count), 8);
    bus.byte_sel = 1'b1;
    #1;
    check("toggle3_hi_byte", int'(bus.data_out), 0);
    run(4'd3, 1'b0, 64, 1'b1, 1'b0);

    // Zero-length window
    run(4'd3, 1'b0, 0, 1'b0, 1'b0);
    check("win0_count", int'(bus.count), 0);

    // Selection change and start pulse during COUNT
    run(4'd3, 1'b0, 40, 1'b0, 1'b1);

    // Only oscillator 5 toggles
    wmask = 16'h0020; whp = 3;
    run(4'd5, 1'b0, 50, 1'b0, 1'b0);
    run(4'd0, 1'b1, 50, 1'b0, 1'b0);
    if (!XOR_EN) check("xor_disabled_count", int'(bus.count), 0);

    // Reset in the middle of COUNT, then start in the first cycle after release
    wmask = 16'h0002; whp = 2;
    issue(4'd1, 1'b0, 60, 1'b0);
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_zero("midrst");
    q16.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    run(4'd1, 1'b0, 20, 1'b1, 1'b0);

    // Randomised measurements
    for (int i = 0; i < 24; i++) begin
      wmode = int'($urandom_range(0, 1));
      wmask = 16'($urandom);
      whp   = int'($urandom_range(1, 6));
      run(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 70)),
          1'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    end

    // Narrow counter: saturation, then a non-saturating run clears overflow
    wmode = 0; wmask = 16'h0001; whp = 2;
    run4(100);
    check("sat4_count", int'(bus4.count), 15);
    check("sat4_overflow", int'(bus4.overflow), 1);
    run4(20);
    check("nosat4_overflow", int'(bus4.overflow), 0);

    for (int i = 0; i < 50 && (q16.size() != 0 || q4.size() != 0); i++) @(negedge clk);
    check("queue_drain", q16.size() + q4.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/ro_freq_counter.md
RO_FREQ_COUNTER -- requirements
Module: ro_freq_counter

Interface
REQ-001 SHALL have parameter CNT_W, default 16, edge-count result width (4..16).
REQ-002 SHALL have parameter WIN_W, default 16, gate-window length width.
REQ-003 SHALL have port clk  input  1  single system clock, all state rising-edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port ro_in  input  16  raw outputs of one ring-oscillator set; asynchronous to clk.
REQ-006 SHALL have port ro_sel  input  4  index of the oscillator to measure.
REQ-007 SHALL have port xor_mode  input  1  measure XOR of all 16 ro_in bits; honoured only with RO_XOR_EN.
REQ-008 SHALL have port win_len  input  WIN_W  gate window length in clk cycles.
REQ-009 SHALL have port start  input  1  single-cycle measurement request.
REQ-010 SHALL have port byte_sel  input  1  result byte select, 0 = bits 7:0, 1 = bits 15:8.
REQ-011 SHALL have port busy  output  1  high in ARM and COUNT.
REQ-012 SHALL have port done  output  1  high in DONE.
REQ-013 SHALL have port overflow  output  1  count saturated in the last measurement.
REQ-014 SHALL have port count  output  CNT_W  held edge count.
REQ-015 SHALL have port data_out  output  8  selected byte of count, zero-extended to 16 bits.

Function
REQ-016 SHALL implement states IDLE, ARM, COUNT, DONE.
REQ-017 SHALL accept start only in IDLE or DONE; start during ARM or COUNT is ignored.
REQ-018 On accepted start SHALL latch ro_sel, xor_mode and win_len, clear count and overflow, and enter ARM.
REQ-019 SHALL form the measured bit from the latched selection, pass it through a 2-flop synchroniser, and register it a third time for edge detection; the chain runs in every state.
REQ-020 SHALL stay in ARM exactly 3 cycles to flush the synchroniser, then enter COUNT, or DONE if latched win_len = 0.
REQ-021 SHALL stay in COUNT exactly win_len cycles.
REQ-022 SHALL increment count once per cycle in COUNT where the synchronised bit is 1 and its delayed copy is 0.
REQ-023 SHALL ignore rising edges outside COUNT.
REQ-024 SHALL hold count at all-ones on a further rising edge and set overflow; overflow is sticky until the next accepted start.
REQ-025 Timing: with start accepted at edge k, busy SHALL be high for cycles k+1..k+3+win_len and done SHALL be high from cycle k+4+win_len.
REQ-026 SHALL keep done, count and overflow in DONE until the next accepted start or reset.
REQ-027 SHALL ignore changes on ro_sel, xor_mode and win_len after latch.
REQ-028 data_out SHALL be combinational from the count register and byte_sel; bits at or above CNT_W read 0.

Reset
REQ-029 rst high SHALL immediately force IDLE and clear busy, done, overflow, count, data_out, the latched selection and the synchroniser flops, including mid-measurement.
REQ-030 SHALL accept start in the first cycle after rst deasserts.

Configuration
REQ-031 With RO_XOR_EN defined and latched xor_mode = 1, the measured bit SHALL be the XOR-reduction of ro_in; otherwise it is ro_in[latched ro_sel].
REQ-032 Without RO_XOR_EN, xor_mode SHALL be ignored and no XOR tree synthesised; the port list SHALL be identical with and without the macro.

Structure
REQ-033 Package ro_meas_pkg SHALL hold the state enum, the ARM flush length (3) and the byte-select encodings.
REQ-034 The synchroniser and edge detector SHALL be the sub-module ro_edge_sync, with ports clk, rst, d and rise.

Verification
REQ-035 Assert rst mid-run -> all outputs 0 in the same cycle; after release, start accepted.
REQ-036 Toggle ro_in[3] every 4 cycles; ro_sel=3, win_len=64, start -> done at k+68, count=8, overflow=0, data_out=8 for byte_sel=0 and 0 for byte_sel=1.
REQ-037 win_len=0, start -> busy for 3 cycles, done at k+4, count=0.
REQ-038 Change ro_sel and pulse start during COUNT -> no effect on the result or timing.
REQ-039 CNT_W=4; toggle ro_in[0] every 2 cycles; win_len=100 -> count=15, overflow=1.
REQ-040 Only ro_in[5] toggling, xor_mode=1 -> with RO_XOR_EN, count equals the ro_sel=5 result; without RO_XOR_EN and ro_sel=0, count=0.
